// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants and FSM encoding for the systolic skew feeder.
// Optional feature macro: FEEDER_ABORT_EN (adds an abort input to the interface).
package systolic_skew_feeder_pkg;

  localparam int DATA_W       = 16;  // operand lane width
  localparam int N            = 4;   // lanes per bus
  localparam int MAX_K        = 16;  // deepest tile the buffer holds
  localparam int DRAIN_CYCLES = 4;   // zero-operand cycles after the last skewed beat

  localparam int BUS_W  = N * DATA_W;
  localparam int ADDR_W = $clog2(MAX_K);
  localparam int KLEN_W = 5;         // k_len port width
  localparam int STEP_W = 6;         // holds k_len + N - 2 without wrapping

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // A tile length is usable only when it fits the buffer and is non-empty.
  function automatic logic klen_legal(input logic [KLEN_W-1:0] k);
    return (k != '0) && (k <= KLEN_W'(MAX_K));
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Loader-side handshake plus cluster-side operand bus of the skew feeder.
// Optional feature macro: FEEDER_ABORT_EN (adds abort, driven by the master).
interface systolic_skew_feeder_if;
  import systolic_skew_feeder_pkg::*;

  logic              start;
  logic [KLEN_W-1:0] k_len;
  logic              in_valid;
  logic              in_ready;
  logic [BUS_W-1:0]  in_act;
  logic [BUS_W-1:0]  in_wgt;
  logic [BUS_W-1:0]  activations;
  logic [BUS_W-1:0]  weights;
  logic              en;
  logic              busy;
  logic              done;

`ifdef FEEDER_ABORT_EN
  logic              abort;

  modport master (
    output start, k_len, in_valid, in_act, in_wgt, abort,
    input  in_ready, activations, weights, en, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_act, in_wgt, abort,
    output in_ready, activations, weights, en, busy, done
  );
`else
  modport master (
    output start, k_len, in_valid, in_act, in_wgt,
    input  in_ready, activations, weights, en, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_act, in_wgt,
    output in_ready, activations, weights, en, busy, done
  );
`endif

endinterface

// File: rtl/systolic_skew_feeder_buffer.sv
// Tile buffer: MAX_K entries of {wgt, act} beats, one write port and one read
// port per skew lane. Read port i only returns lane i of the addressed entry,
// since that is the only lane the skew stage ever needs from that port.
module systolic_skew_feeder_buffer
  import systolic_skew_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [BUS_W-1:0]  wr_act_i,
  input  logic [BUS_W-1:0]  wr_wgt_i,
  input  logic [ADDR_W-1:0] rd_addr_i [N],
  output logic [DATA_W-1:0] rd_act_o  [N],
  output logic [DATA_W-1:0] rd_wgt_o  [N]
);

  logic [BUS_W-1:0] act_mem [MAX_K];
  logic [BUS_W-1:0] wgt_mem [MAX_K];

  // Store one loader beat; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      act_mem[wr_addr_i] <= wr_act_i;
      wgt_mem[wr_addr_i] <= wr_wgt_i;
    end
  end

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_rd
    assign rd_act_o[gi] = act_mem[rd_addr_i[gi]][gi*DATA_W +: DATA_W];
    assign rd_wgt_o[gi] = wgt_mem[rd_addr_i[gi]][gi*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Systolic skew feeder: buffers a K-beat operand tile, then streams it to the
// PE cluster with lane i delayed i cycles, keeping en high through the drain.
// Optional feature macro: FEEDER_ABORT_EN (abort input cancels any pass).
// Cluster-facing outputs reflect the state of the previous cycle, so the first
// skewed beat appears one cycle after the buffer stops loading; in_ready is
// derived from the next state so it drops right as LOAD is left.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_skew_feeder_if.slave bus
);

  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(DRAIN_CYCLES - 1);

  state_t            state_q;
  logic [KLEN_W-1:0] klen_q;
  logic [KLEN_W-1:0] cnt_q;     // beats accepted so far
  logic [STEP_W-1:0] step_q;    // skew step in STREAM, drain count in DRAIN
  logic              in_ready_q;
  logic              en_q;
  logic              busy_q;
  logic              done_q;
  logic [BUS_W-1:0]  act_q;
  logic [BUS_W-1:0]  wgt_q;

  logic              abort_w;
  logic              wr_en;
  logic              last_beat;
  logic [STEP_W-1:0] last_step;
  logic [ADDR_W-1:0] rd_addr [N];
  logic [DATA_W-1:0] rd_act  [N];
  logic [DATA_W-1:0] rd_wgt  [N];
  logic [BUS_W-1:0]  act_skew;
  logic [BUS_W-1:0]  wgt_skew;

`ifdef FEEDER_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  assign wr_en     = (state_q == ST_LOAD) && bus.in_valid && in_ready_q;
  assign last_beat = (cnt_q == klen_q - KLEN_W'(1));
  assign last_step = STEP_W'(klen_q) + STEP_W'(N - 2);

  systolic_skew_feeder_buffer u_buffer (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (cnt_q[ADDR_W-1:0]),
    .wr_act_i  (bus.in_act),
    .wr_wgt_i  (bus.in_wgt),
    .rd_addr_i (rd_addr),
    .rd_act_o  (rd_act),
    .rd_wgt_o  (rd_wgt)
  );

  // Lane i shows beat (step - i); outside the tile the lane carries zero.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_skew
    logic [STEP_W-1:0] idx;
    logic              lane_ok;
    assign idx         = step_q - STEP_W'(gi);
    assign lane_ok     = (step_q >= STEP_W'(gi)) && (idx < STEP_W'(klen_q));
    assign rd_addr[gi] = idx[ADDR_W-1:0];
    assign act_skew[gi*DATA_W +: DATA_W] = lane_ok ? rd_act[gi] : '0;
    assign wgt_skew[gi*DATA_W +: DATA_W] = lane_ok ? rd_wgt[gi] : '0;
  end

  // Pass sequencing, beat/step counters and the registered cluster outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      klen_q     <= '0;
      cnt_q      <= '0;
      step_q     <= '0;
      in_ready_q <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      act_q      <= '0;
      wgt_q      <= '0;
    end else if (abort_w && (state_q != ST_IDLE)) begin
      // Abort wins over everything else: silent return to IDLE, no done.
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      in_ready_q <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      act_q      <= '0;
      wgt_q      <= '0;
    end else begin
      en_q   <= (state_q == ST_STREAM) || (state_q == ST_DRAIN);
      done_q <= (state_q == ST_DONE);
      act_q  <= (state_q == ST_STREAM) ? act_skew : '0;
      wgt_q  <= (state_q == ST_STREAM) ? wgt_skew : '0;

      case (state_q)
        ST_IDLE: begin
          if (bus.start && klen_legal(bus.k_len)) begin
            klen_q     <= bus.k_len;
            cnt_q      <= '0;
            step_q     <= '0;
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            cnt_q <= cnt_q + KLEN_W'(1);
            if (last_beat) begin
              state_q    <= ST_STREAM;
              in_ready_q <= 1'b0;
              step_q     <= '0;
            end
          end
        end
        ST_STREAM: begin
          if (step_q == last_step) begin
            state_q <= ST_DRAIN;
            step_q  <= '0;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        ST_DRAIN: begin
          if (step_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            step_q  <= '0;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.en          = en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.activations = act_q;
  assign bus.weights     = wgt_q;

endmodule
